// File: rtl/ks_mem_pkg.sv
// Shared types for the program/data RAM arbiter: FSM states, owner encoding
// and the default RAM geometry.
package ks_mem_pkg;

  localparam int unsigned KS_ADDR_WIDTH = 8;
  localparam int unsigned KS_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_HOST = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  function automatic owner_t state_owner(input arb_state_t state);
    return (state == ARB_HOST) ? OWN_HOST : OWN_CPU;
  endfunction

endpackage

// File: rtl/arb_lock_timer.sv
// Counts consecutive cycles in which a host lock is blocking a waiting CPU and
// flags the cycle in which the count reaches LOCK_TIMEOUT.
module arb_lock_timer #(
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_count_en,
  output logic o_expire
);

  localparam int unsigned CntWidth = $clog2(LOCK_TIMEOUT + 1);

  logic [CntWidth-1:0] r_count;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst || !i_count_en) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CntWidth'(1);
    end
  end

  // The expiring cycle is itself the LOCK_TIMEOUT-th blocked cycle.
  assign o_expire = i_count_en && (r_count == CntWidth'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the CPU
// memory port and the host/debug loader. Optional macro ARB_LOCK_TIMEOUT_EN
// bounds how long a host lock may starve a requesting CPU.
module ram_arbiter
  import ks_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = KS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = KS_DATA_WIDTH,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // CPU port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  // Host port
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_lock,
  output logic                  host_ack,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  // RAM macro
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  // Status
  output logic                  owner,
  output logic                  lock_timeout
);

  if (LOCK_TIMEOUT < 1) begin : g_bad_lock_timeout
    $error("ram_arbiter: LOCK_TIMEOUT must be at least 1");
  end

  arb_state_t r_state;
  arb_state_t w_next_state;
  owner_t     r_last_served;
  logic       r_cpu_rvalid;
  logic       r_host_rvalid;
  logic       w_lock;
  logic       w_force_cpu;

`ifdef ARB_LOCK_TIMEOUT_EN
  logic r_lock_timeout;
  logic r_lock_block;
  logic w_count_en;
  logic w_expire;

  // After a timeout the lock stays disarmed until the host releases it once.
  assign w_lock     = host_lock & ~r_lock_block;
  assign w_count_en = (r_state == ARB_HOST) & w_lock & cpu_req;

  arb_lock_timer #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_timer (
    .clk       (clk),
    .rst       (rst),
    .i_count_en(w_count_en),
    .o_expire  (w_expire)
  );

  assign w_force_cpu = w_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_timeout <= 1'b0;
      r_lock_block   <= 1'b0;
    end else if (w_expire) begin
      r_lock_timeout <= 1'b1;
      r_lock_block   <= 1'b1;
    end else if (!host_lock) begin
      r_lock_block   <= 1'b0;
    end
  end

  assign lock_timeout = r_lock_timeout;
`else
  assign w_lock       = host_lock;
  assign w_force_cpu  = 1'b0;
  assign lock_timeout = 1'b0;
`endif

  // Access issue and next-state decision for the current owner.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    cpu_ack      = 1'b0;
    host_ack     = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;

    unique case (r_state)
      ARB_IDLE: begin
        unique case ({cpu_req, host_req})
          2'b10:   w_next_state = ARB_CPU;
          2'b01:   w_next_state = ARB_HOST;
          2'b11:   w_next_state = (r_last_served == OWN_HOST) ? ARB_CPU : ARB_HOST;
          default: w_next_state = ARB_IDLE;
        endcase
      end

      ARB_CPU: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (cpu_req) begin
          cpu_ack = 1'b1;
          ram_en  = 1'b1;
          ram_we  = cpu_we;
        end
        if (host_req)     w_next_state = ARB_HOST;
        else if (cpu_req) w_next_state = ARB_CPU;
        else              w_next_state = ARB_IDLE;
      end

      ARB_HOST: begin
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        if (host_req) begin
          host_ack = 1'b1;
          ram_en   = 1'b1;
          ram_we   = host_we;
        end
        if (w_force_cpu)   w_next_state = ARB_CPU;
        else if (w_lock)   w_next_state = ARB_HOST;
        else if (cpu_req)  w_next_state = ARB_CPU;
        else if (host_req) w_next_state = ARB_HOST;
        else               w_next_state = ARB_IDLE;
      end

      default: w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_last_served <= OWN_HOST;
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cpu_rvalid  <= cpu_ack & ~cpu_we;
      r_host_rvalid <= host_ack & ~host_we;
      if (cpu_ack)       r_last_served <= OWN_CPU;
      else if (host_ack) r_last_served <= OWN_HOST;
    end
  end

  assign owner       = logic'(state_owner(r_state));
  assign cpu_stall   = cpu_req & ~cpu_ack;
  assign cpu_rvalid  = r_cpu_rvalid;
  assign host_rvalid = r_host_rvalid;
  // The RAM answers the access acked last cycle; rvalid says whose it was.
  assign cpu_rdata   = ram_rdata;
  assign host_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed sequences, a per-cycle vector
// table and a randomized run scored against a shadow memory and fairness rules.
module tb_ram_arbiter;
  import ks_mem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_lock, host_ack, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          owner, lock_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .LOCK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner), .lock_timeout(lock_timeout)
  );

  // Single-port synchronous RAM macro model.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_all_quiet(input string name);
    check(name, {cpu_ack, cpu_rvalid, cpu_stall, host_ack, host_rvalid,
                 ram_en, ram_we, owner, lock_timeout}, 9'b0);
  endtask

  // One complete access on either port with a bounded wait for ack.
  task automatic access(input bit is_host, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input string tag);
    bit got = 0;
    if (is_host) begin host_req = 1; host_we = we; host_addr = addr; host_wdata = wdata; end
    else         begin cpu_req  = 1; cpu_we  = we; cpu_addr  = addr; cpu_wdata  = wdata; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (is_host ? host_ack : cpu_ack) got = 1;
      next_cycle();
    end
    check({tag, "_ack_seen"}, 64'(got), 64'd1);
    cpu_req = 0; host_req = 0;
    @(negedge clk);
    check({tag, "_rvalid"}, 64'(is_host ? host_rvalid : cpu_rvalid), 64'(!we));
    if (!we) check({tag, "_rdata"}, is_host ? host_rdata : cpu_rdata, 64'(exp_rdata));
    next_cycle();
  endtask

  // {cpu_req, host_req, host_lock, exp cpu_ack, exp host_ack, exp owner}
  typedef struct packed {
    bit c_req; bit h_req; bit h_lock; bit e_cack; bit e_hack; bit e_owner;
  } vec_t;

  localparam vec_t VECS [21] = '{
    6'b110_000, 6'b110_100, 6'b110_011, 6'b110_100, 6'b110_011, 6'b110_100,
    6'b110_011, 6'b000_000, 6'b011_000, 6'b011_011, 6'b101_001, 6'b101_001,
    6'b100_001, 6'b100_100, 6'b111_100, 6'b111_011, 6'b111_011, 6'b110_011,
    6'b110_100, 6'b000_001, 6'b000_000
  };

  logic [DW-1:0] shadow [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 16'h0100);
    mem[8'h10] = 16'h1234;

    // Reset state and first-read latency.
    do_reset();
    @(negedge clk);
    check_all_quiet("reset_outputs");
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    @(negedge clk);
    check("rd_idle_no_ack", 64'(cpu_ack), 64'd0);
    next_cycle();
    @(negedge clk);
    check("rd_ack_owner_ram", {cpu_ack, owner, ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h10});
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    check("rd_rvalid_data", {cpu_rvalid, cpu_rdata}, {1'b1, 16'h1234});
    next_cycle();

    // Write then read back through the CPU port.
    access(1'b0, 1'b1, 8'h20, 16'h00FF, 16'h0000, "cpu_wr20");
    access(1'b0, 1'b0, 8'h20, 16'h0000, 16'h00FF, "cpu_rd20");
    access(1'b1, 1'b0, 8'h20, 16'h0000, 16'h00FF, "host_rd20");

    // Per-cycle arbitration table.
    do_reset();
    cpu_addr = 8'h30; host_addr = 8'h31;
    for (int i = 0; i < 21; i++) begin
      cpu_req = VECS[i].c_req; host_req = VECS[i].h_req; host_lock = VECS[i].h_lock;
      @(negedge clk);
      check($sformatf("vec%0d", i), {cpu_ack, host_ack, owner, cpu_stall},
            {VECS[i].e_cack, VECS[i].e_hack, VECS[i].e_owner, VECS[i].c_req & ~VECS[i].e_cack});
      next_cycle();
    end

    // Reset right after a host read ack discards the pending rvalid.
    do_reset();
    begin
      bit got = 0;
      host_req = 1; host_we = 0; host_addr = 8'h10;
      for (int i = 0; i < 4 && !got; i++) begin
        @(negedge clk);
        if (host_ack) got = 1;
        else next_cycle();
      end
      check("abort_host_ack_seen", 64'(got), 64'd1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; host_req = 0;
      @(negedge clk);
      check_all_quiet("abort_outputs");
      next_cycle();
      cpu_req = 1; cpu_addr = 8'h10;
      @(negedge clk);
      check("abort_back_in_idle", 64'(cpu_ack), 64'd0);
      next_cycle();
      @(negedge clk);
      check("abort_then_cpu_ack", 64'(cpu_ack), 64'd1);
      next_cycle();
      cpu_req = 0;
      next_cycle();
    end

`ifndef ARB_LOCK_TIMEOUT_EN
    // Locked host burst while the CPU waits.
    do_reset();
    host_req = 1; host_we = 1; host_lock = 1; host_addr = 8'h00; host_wdata = 16'hAAAA;
    @(negedge clk);
    check("burst_idle_no_ack", 64'(host_ack), 64'd0);
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
    for (int i = 0; i < 8; i++) begin
      host_addr = AW'(i);
      @(negedge clk);
      check($sformatf("burst_host_ack_%0d", i), {host_ack, cpu_stall, owner}, 3'b111);
      next_cycle();
    end
    host_req = 0; host_lock = 0;
    begin
      bit got = 0;
      for (int i = 0; i < 2 && !got; i++) begin
        @(negedge clk);
        if (cpu_ack) got = 1;
        next_cycle();
      end
      check("unlock_cpu_ack_within_2", 64'(got), 64'd1);
    end
    cpu_req = 0;
    for (int i = 0; i < 8; i++) check($sformatf("burst_mem_%0d", i), mem[i], 64'hAAAA);
    next_cycle();

    // Idle locked host starves the CPU indefinitely.
    do_reset();
    host_req = 1; host_lock = 1; host_addr = 8'h50;
    next_cycle();
    next_cycle();
    host_req = 0; cpu_req = 1;
    begin
      int acks = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (cpu_ack) acks++;
        next_cycle();
      end
      @(negedge clk);
      check("starve_no_cpu_ack", 64'(acks), 64'd0);
      check("starve_owner_flag", {owner, cpu_stall, lock_timeout}, 3'b110);
    end
    next_cycle();
    idle_inputs();
`else
    // Lock timeout forces the CPU in after LOCK_TIMEOUT blocked cycles.
    do_reset();
    host_req = 1; host_lock = 1; host_addr = 8'h50;
    next_cycle();
    cpu_req = 1; cpu_addr = 8'h51;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("to_locked_%0d", i), {owner, host_ack, lock_timeout}, 3'b110);
      next_cycle();
    end
    @(negedge clk);
    check("to_forced_cpu", {owner, cpu_ack, lock_timeout}, 3'b011);
    next_cycle();
    @(negedge clk);
    check("to_host_again", {owner, host_ack}, 2'b11);
    next_cycle();
    @(negedge clk);
    check("to_lock_ignored", {owner, cpu_ack, lock_timeout}, 3'b011);
    next_cycle();
    idle_inputs();
`endif

    // Randomized run against a shadow memory and the fairness bounds.
    do_reset();
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    begin
      bit pc = 0, ph = 0;
      bit exp_crv = 0, exp_hrv = 0;
      logic [DW-1:0] exp_cd = '0, exp_hd = '0;
      int c_wait = 0, h_wait = 0, c_other = 0, h_other = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (!pc) begin
          if ($urandom_range(0, 99) < 60) begin
            pc = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
          end else cpu_req = 0;
        end
        if (!ph) begin
          if ($urandom_range(0, 99) < 60) begin
            ph = 1; host_req = 1; host_we = 1'($urandom_range(0, 1));
            host_addr = AW'($urandom_range(0, 15)); host_wdata = DW'($urandom);
          end else host_req = 0;
        end
        @(negedge clk);
        check("rnd_single_grant", 64'(cpu_ack & host_ack), 64'd0);
        check("rnd_stall", 64'(cpu_stall), 64'(cpu_req & ~cpu_ack));
        check("rnd_cpu_rvalid", 64'(cpu_rvalid), 64'(exp_crv));
        if (exp_crv) check("rnd_cpu_rdata", cpu_rdata, 64'(exp_cd));
        check("rnd_host_rvalid", 64'(host_rvalid), 64'(exp_hrv));
        if (exp_hrv) check("rnd_host_rdata", host_rdata, 64'(exp_hd));
        if (cpu_ack)
          check("rnd_cpu_drive", {cpu_req, owner, ram_en, ram_we, ram_addr, ram_wdata},
                {1'b1, 1'b0, 1'b1, cpu_we, cpu_addr, cpu_wdata});
        else if (host_ack)
          check("rnd_host_drive", {host_req, owner, ram_en, ram_we, ram_addr, ram_wdata},
                {1'b1, 1'b1, 1'b1, host_we, host_addr, host_wdata});
        else
          check("rnd_no_access", 64'(ram_en), 64'd0);

        exp_crv = cpu_ack & ~cpu_we;
        exp_hrv = host_ack & ~host_we;
        if (exp_crv) exp_cd = shadow[cpu_addr];
        if (exp_hrv) exp_hd = shadow[host_addr];
        if (cpu_ack && cpu_we)   shadow[cpu_addr]  = cpu_wdata;
        if (host_ack && host_we) shadow[host_addr] = host_wdata;

        if (pc && !cpu_ack) c_wait++; else c_wait = 0;
        if (ph && !host_ack) h_wait++; else h_wait = 0;
        if (pc && host_ack) c_other++;
        if (ph && cpu_ack) h_other++;
        if (c_wait > 2 || c_other > 1)
          check("rnd_cpu_fairness", {32'(c_wait), 32'(c_other)}, 64'd0);
        if (h_wait > 2 || h_other > 1)
          check("rnd_host_fairness", {32'(h_wait), 32'(h_other)}, 64'd0);
        if (cpu_ack)  begin pc = 0; c_other = 0; end
        if (host_ack) begin ph = 0; h_other = 0; end
        next_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
